// File: rtl/siso_frame_ctrl_pkg.sv
// Shared types and constants for the SISO frame controller.
// Holds the chain geometry and the controller state encoding.
package siso_pkg;

   localparam int SISO_WIDTH = 6;
   localparam int SISO_LAT   = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/siso_frame_ctrl_bit_sr.sv
// siso_bit_sr: WIDTH-bit shift register with parallel load, serial in/out.
// Ports: clk/rst, load_i+load_val_i, shift_i+ser_i, q_o, ser_o (head bit),
// nxt_o (value the register takes on a shift, for same-edge consumers).
module siso_bit_sr #(
   parameter int WIDTH     = 6,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] q_o,
   output logic             ser_o,
   output logic [WIDTH-1:0] nxt_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // MSB-first: head is the top bit, new bits enter at the bottom.
   // LSB-first: mirror image, so both ends keep the same word order.
   generate
      if (MSB_FIRST) begin : g_msb
         assign nxt_o = {data_q[WIDTH-2:0], ser_i};
         assign ser_o = data_q[WIDTH-1];
      end else begin : g_lsb
         assign nxt_o = {ser_i, data_q[WIDTH-1:1]};
         assign ser_o = data_q[0];
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_val_i;
      end else if (shift_i) begin
         data_d = nxt_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/siso_frame_ctrl.sv
// siso_frame_ctrl: serialises a word through a siso_6_bit chain and
// recaptures it. Host side: in_* / out_* valid-ready; chain side: sr_*.
module siso_frame_ctrl
   import siso_pkg::*;
#(
   parameter int WIDTH     = SISO_WIDTH,
   parameter int LAT       = SISO_LAT,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             sr_d,
   output logic             sr_reset,
   output logic             sr_preset,
   input  logic             sr_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             err,
   output logic             busy
);

   localparam int CW = $clog2(LAT + WIDTH);
   localparam logic [CW-1:0] TX_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] RX_FIRST = CW'(LAT);
   localparam logic [CW-1:0] LAST     = CW'(LAT + WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             sr_d_q, sr_d_d;
   logic             sr_reset_q, sr_reset_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] tx_copy_q, tx_copy_d;

   logic             tx_load, tx_shift, tx_ser;
   logic             rx_load, rx_shift;
   logic [WIDTH-1:0] tx_q, tx_nxt;
   logic [WIDTH-1:0] rx_q, rx_nxt;

   siso_bit_sr #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_tx_sh (
      .clk        (clk),
      .rst        (reset),
      .load_i     (tx_load),
      .load_val_i (in_data),
      .shift_i    (tx_shift),
      .ser_i      (1'b0),
      .q_o        (tx_q),
      .ser_o      (tx_ser),
      .nxt_o      (tx_nxt)
   );

   siso_bit_sr #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_rx_sh (
      .clk        (clk),
      .rst        (reset),
      .load_i     (rx_load),
      .load_val_i ('0),
      .shift_i    (rx_shift),
      .ser_i      (sr_q),
      .q_o        (rx_q),
      .ser_o      (),
      .nxt_o      (rx_nxt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d_d      = 1'b0;
      sr_reset_d  = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
      tx_copy_d   = tx_copy_q;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      rx_load     = 1'b0;
      rx_shift    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               tx_load    = 1'b1;
               rx_load    = 1'b1;
               tx_copy_d  = in_data;
               cnt_d      = '0;
               sr_reset_d = 1'b1;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            // sr_d is registered: present bit 0 for RUN cnt=0.
            sr_d_d   = tx_ser;
            tx_shift = 1'b1;
            cnt_d    = '0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q < TX_LAST) begin
               sr_d_d   = tx_ser;
               tx_shift = 1'b1;
            end
            if (cnt_q >= RX_FIRST) begin
               rx_shift = 1'b1;
            end
            // Last bit arrives this cycle; use the post-shift word.
            if (cnt_q == LAST) begin
               out_data_d  = rx_nxt;
               err_d       = (rx_nxt != tx_copy_q);
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         sr_d_q      <= 1'b0;
         sr_reset_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
         tx_copy_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         sr_d_q      <= sr_d_d;
         sr_reset_q  <= sr_reset_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         tx_copy_q   <= tx_copy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign sr_d      = sr_d_q;
   assign sr_reset  = sr_reset_q;
   assign sr_preset = 1'b0;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
